// File: rtl/fpu_mul_v4sf_seq_if.sv
// Packed-FP dispatch/result handshake between the EX stage and the v4sf multiply sequencer.
interface fpu_mul_v4sf_seq_if #(
    parameter int unsigned LANES = 4
);
    logic                    opValid;
    logic                    opReady;
    logic [32*LANES-1:0]     opValRs;
    logic [32*LANES-1:0]     opValRt;
    logic [LANES-1:0]        opMask;
    logic                    outValid;
    logic                    outReady;
    logic [32*LANES-1:0]     outValRo;

    modport master (
        output opValid, opValRs, opValRt, opMask, outReady,
        input  opReady, outValid, outValRo
    );

    modport slave (
        input  opValid, opValRs, opValRt, opMask, outReady,
        output opReady, outValid, outValRo
    );
endinterface

// File: rtl/fpu_mul_v4sf_seq.sv
// Issues a packed 4 x binary32 multiply one lane per cycle through the shared scalar
// multiplier and reassembles the lane results as they leave its fixed-latency pipeline.
module fpu_mul_v4sf_seq #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                exHold,
    fpu_mul_v4sf_seq_if.slave   disp_io,
    output logic [31:0]         mulValRs,
    output logic [31:0]         mulValRt,
    output logic                mulHold,
    input  logic [31:0]         mulValRo
);
    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                 state_q;
    logic [32*LANES-1:0]    rs_q, rt_q, res_q;
    logic [LANES-1:0]       pend_q, pend_d;
    logic [31:0]            mul_rs_q, mul_rt_q;
    logic [MUL_LAT-1:0]     trk_vld_q, trk_vld_d;
    logic [LaneW-1:0]       trk_lane_q [MUL_LAT];
    logic [LaneW-1:0]       trk_lane_d [MUL_LAT];
    logic [LaneW-1:0]       sel_idx;
    logic                   issue;
    logic                   cap;
    logic [LaneW-1:0]       cap_lane;

    // Lowest-index pending lane is issued first.
    always_comb begin
        sel_idx = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = LaneW'(i);
        end
        pend_d          = pend_q;
        pend_d[sel_idx] = 1'b0;
    end

    assign issue = (state_q == StIssue);

    // Tracker shifts one stage per unheld cycle; the oldest stage lines up with mulValRo.
    always_comb begin
        trk_vld_d[0]  = issue;
        trk_lane_d[0] = sel_idx;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            trk_vld_d[i]  = trk_vld_q[i-1];
            trk_lane_d[i] = trk_lane_q[i-1];
        end
    end

    assign cap      = trk_vld_q[MUL_LAT-1];
    assign cap_lane = trk_lane_q[MUL_LAT-1];

    assign mulValRs = issue ? rs_q[32*sel_idx +: 32] : mul_rs_q;
    assign mulValRt = issue ? rt_q[32*sel_idx +: 32] : mul_rt_q;
    assign mulHold  = exHold;

    assign disp_io.opReady  = (state_q == StIdle) && !exHold;
    assign disp_io.outValid = (state_q == StDone);
    assign disp_io.outValRo = res_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            rs_q      <= '0;
            rt_q      <= '0;
            res_q     <= '0;
            pend_q    <= '0;
            mul_rs_q  <= '0;
            mul_rt_q  <= '0;
            trk_vld_q <= '0;
            for (int i = 0; i < int'(MUL_LAT); i++) trk_lane_q[i] <= '0;
        end else if (!exHold) begin
            trk_vld_q  <= trk_vld_d;
            trk_lane_q <= trk_lane_d;
            if (cap) res_q[32*cap_lane +: 32] <= mulValRo;
            unique case (state_q)
                StIdle: begin
                    if (disp_io.opValid) begin
                        rs_q    <= disp_io.opValRs;
                        rt_q    <= disp_io.opValRt;
                        pend_q  <= disp_io.opMask;
                        res_q   <= '0;
                        state_q <= (disp_io.opMask == '0) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    mul_rs_q <= rs_q[32*sel_idx +: 32];
                    mul_rt_q <= rt_q[32*sel_idx +: 32];
                    pend_q   <= pend_d;
                    if (pend_d == '0) state_q <= StDrain;
                end
                StDrain: begin
                    if (trk_vld_d == '0) state_q <= StDone;
                end
                StDone: begin
                    if (disp_io.outReady) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
